// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} fetch_state_t;

  // Source for the fetch-address register when it is loaded.
  typedef enum logic [1:0] {NPC_SEQ, NPC_REDIR, NPC_TGT, NPC_RESET} npc_sel_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request side plus decoder/redirect side.
// FETCH_MISALIGN_TRAP_EN adds the misaligned status line.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
    output misaligned,
`endif
    output mem_req, mem_addr, instr, instr_valid, pc,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
    input  misaligned,
`endif
    input  mem_req, mem_addr, instr, instr_valid, pc,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_pc.sv
// Fetch address / PC datapath: request address, instruction PC, discard flag
// and pending redirect target. FETCH_MISALIGN_TRAP_EN keeps raw redirect bits.
module fetch_pc import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_ld_i,
  input  npc_sel_t    addr_sel_i,
  input  logic        pc_ld_i,
  input  logic        disc_set_i,
  input  logic        disc_clr_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] addr_o,
  output logic [31:0] pc_o,
  output logic        discard_o
);
  logic [31:0] addr_q, addr_d, pc_q, tgt_q, redir_pc;
  logic        disc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  // A misaligned target halts the unit, so it is never actually requested.
  assign redir_pc = redirect_pc_i;
`else
  assign redir_pc = word_align(redirect_pc_i);
`endif

  always_comb begin
    addr_d = addr_q;
    if (addr_ld_i) begin
      case (addr_sel_i)
        NPC_SEQ:   addr_d = pc_q + 32'd4;
        NPC_REDIR: addr_d = redir_pc;
        NPC_TGT:   addr_d = tgt_q;
        default:   addr_d = RESET_PC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= RESET_PC;
      pc_q   <= RESET_PC;
      tgt_q  <= RESET_PC;
      disc_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (pc_ld_i) pc_q <= addr_q;
      if (disc_set_i) begin
        disc_q <= 1'b1;
        tgt_q  <= redir_pc;
      end else if (disc_clr_i) begin
        disc_q <= 1'b0;
      end
    end
  end

  assign addr_o    = addr_q;
  assign pc_o      = pc_q;
  assign discard_o = disc_q;
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with redirect/discard handling.
// FETCH_MISALIGN_TRAP_EN enables the HALT-on-misaligned-redirect trap.
module fetch_unit import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, pc_w, addr_w;
  logic         addr_ld, pc_ld, disc_set, disc_clr, discard, trap;
  logic         mem_req, instr_valid;
  npc_sel_t     addr_sel;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = trap ? HALT : FETCH;
      FETCH:   if (trap) state_d = HALT;
               else if (bus.mem_ack && !bus.redirect && !discard) state_d = VALID;
      VALID:   if (trap) state_d = HALT;
               else if (bus.redirect || bus.instr_ready) state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls; a returning word is kept only if no redirect is live or pending.
  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    addr_ld     = 1'b0;
    addr_sel    = NPC_SEQ;
    pc_ld       = 1'b0;
    disc_set    = 1'b0;
    disc_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        addr_ld  = 1'b1;
        addr_sel = bus.redirect ? NPC_REDIR : NPC_RESET;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          if (bus.redirect || discard) begin
            addr_ld  = 1'b1;
            addr_sel = bus.redirect ? NPC_REDIR : NPC_TGT;
            disc_clr = 1'b1;
          end else begin
            pc_ld = 1'b1;
          end
        end else if (bus.redirect) begin
          disc_set = 1'b1;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (bus.redirect) begin
          addr_ld  = 1'b1;
          addr_sel = NPC_REDIR;
        end else if (bus.instr_ready) begin
          addr_ld  = 1'b1;
          addr_sel = NPC_SEQ;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        instr_q <= 32'h0;
    else if (pc_ld) instr_q <= bus.mem_rdata;
  end

  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk           (clk),
    .rst           (rst),
    .addr_ld_i     (addr_ld),
    .addr_sel_i    (addr_sel),
    .pc_ld_i       (pc_ld),
    .disc_set_i    (disc_set),
    .disc_clr_i    (disc_clr),
    .redirect_pc_i (bus.redirect_pc),
    .addr_o        (addr_w),
    .pc_o          (pc_w),
    .discard_o     (discard)
  );

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = addr_w;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid;
  assign bus.pc          = pc_w;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misaligned  = (state_q == HALT);
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and random traffic against a transaction-level model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic req; logic [31:0] addr; logic vld; logic [31:0] ins; logic [31:0] pc;
    logic ack; logic [31:0] rd; logic rdy; logic redir; logic [31:0] rpc;
  } vec_t;

  function automatic vec_t v(logic req, logic [31:0] addr, logic vld, logic [31:0] ins,
                             logic [31:0] pc, logic ack, logic [31:0] rd, logic rdy,
                             logic redir, logic [31:0] rpc);
    vec_t r;
    r.req = req; r.addr = addr; r.vld = vld; r.ins = ins; r.pc = pc;
    r.ack = ack; r.rd = rd; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
    return r;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] RPC_ODD = 32'h0000_0500;
`else
  localparam logic [31:0] RPC_ODD = 32'h0000_0503;  // low bits must be dropped
`endif

  vec_t tbl [26];

  task automatic drive(input logic ack, input logic [31:0] rd, input logic rdy,
                       input logic redir, input logic [31:0] rpc);
    bus.mem_ack = ack; bus.mem_rdata = rd; bus.instr_ready = rdy;
    bus.redirect = redir; bus.redirect_pc = rpc;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, ".mem_req"}, {31'b0, bus.mem_req}, {31'b0, req});
    chk({tag, ".instr_valid"}, {31'b0, bus.instr_valid}, {31'b0, vld});
    if (req) chk({tag, ".mem_addr"}, bus.mem_addr, addr);
    if (vld) begin
      chk({tag, ".instr"}, bus.instr, ins);
      chk({tag, ".pc"}, bus.pc, pc);
    end
  endtask

  // Transaction-level reference: where the unit is in the flow and which word it holds.
  int          m_ph;      // 0 just out of reset, 1 request outstanding, 2 holding an instruction
  logic [31:0] m_addr, m_tgt, m_pc, m_ins;
  logic        m_drop;

  initial begin
    tbl[0]  = v(0, 32'h0,   0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 32'h0);
    tbl[1]  = v(1, 32'h0,   0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 32'h0);
    tbl[2]  = v(1, 32'h0,   0, 32'h0,        32'h0,   1, 32'h00500093, 0, 0, 32'h0);
    tbl[3]  = v(0, 32'h0,   1, 32'h00500093, 32'h0,   0, 32'h0,        1, 0, 32'h0);
    tbl[4]  = v(1, 32'h4,   0, 32'h0,        32'h0,   1, 32'h11111111, 0, 0, 32'h0);
    for (int i = 5; i <= 9; i++)
      tbl[i] = v(0, 32'h0,  1, 32'h11111111, 32'h4,   0, 32'h0,        0, 0, 32'h0);
    tbl[10] = v(0, 32'h0,   1, 32'h11111111, 32'h4,   0, 32'h0,        1, 0, 32'h0);
    tbl[11] = v(1, 32'h8,   0, 32'h0,        32'h0,   0, 32'h0,        0, 1, 32'h100);
    tbl[12] = v(1, 32'h8,   0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 32'h0);
    tbl[13] = v(1, 32'h8,   0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 32'h0);
    tbl[14] = v(1, 32'h8,   0, 32'h0,        32'h0,   1, 32'hDEADBEEF, 0, 0, 32'h0);
    tbl[15] = v(1, 32'h100, 0, 32'h0,        32'h0,   1, 32'h22222222, 0, 0, 32'h0);
    tbl[16] = v(0, 32'h0,   1, 32'h22222222, 32'h100, 0, 32'h0,        1, 1, 32'h40);
    tbl[17] = v(1, 32'h40,  0, 32'h0,        32'h0,   1, 32'h33333333, 0, 0, 32'h0);
    tbl[18] = v(0, 32'h0,   1, 32'h33333333, 32'h40,  0, 32'h0,        1, 0, 32'h0);
    tbl[19] = v(1, 32'h44,  0, 32'h0,        32'h0,   1, 32'h44444444, 0, 1, 32'h200);
    tbl[20] = v(1, 32'h200, 0, 32'h0,        32'h0,   0, 32'h0,        0, 1, 32'h300);
    tbl[21] = v(1, 32'h200, 0, 32'h0,        32'h0,   0, 32'h0,        0, 1, 32'h400);
    tbl[22] = v(1, 32'h200, 0, 32'h0,        32'h0,   1, 32'h55555555, 0, 0, 32'h0);
    tbl[23] = v(1, 32'h400, 0, 32'h0,        32'h0,   1, 32'h66666666, 0, 0, 32'h0);
    tbl[24] = v(0, 32'h0,   1, 32'h66666666, 32'h400, 0, 32'h0,        0, 1, RPC_ODD);
    tbl[25] = v(1, 32'h500, 0, 32'h0,        32'h0,   0, 32'h0,        0, 0, 32'h0);

    drive(0, 0, 0, 0, 0);
    bus2.mem_ack = 0; bus2.mem_rdata = 0; bus2.instr_ready = 0;
    bus2.redirect = 0; bus2.redirect_pc = 0;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst.mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    chk("rst.instr", bus.instr, 32'h0);
    chk("rst.instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst.pc", bus.pc, 32'h0);
    chk("rst2.pc", bus2.pc, 32'hFFFF_FFFC);
    rst = 1'b0;

    // Directed vectors: outputs checked, then inputs applied for the next edge
    for (int i = 0; i < 26; i++) begin
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].ins, tbl[i].pc);
      drive(tbl[i].ack, tbl[i].rd, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);

    // RESET_PC at top of address space: pc+4 wraps to zero
    #1;
    chk("wrap.mem_addr0", bus2.mem_addr, 32'hFFFF_FFFC);
    bus2.mem_ack = 1; bus2.mem_rdata = 32'hABCD_0001;
    @(negedge clk); #1;
    chk("wrap.valid", {31'b0, bus2.instr_valid}, 32'h1);
    chk("wrap.pc", bus2.pc, 32'hFFFF_FFFC);
    bus2.mem_ack = 0; bus2.instr_ready = 1;
    @(negedge clk); #1;
    chk("wrap.mem_req", {31'b0, bus2.mem_req}, 32'h1);
    chk("wrap.mem_addr1", bus2.mem_addr, 32'h0000_0000);
    bus2.instr_ready = 0;

    // Asynchronous reset mid-FETCH; a late ack in IDLE must be ignored
    #2 rst = 1'b1;
    #1;
    chk("arst.mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("arst.mem_addr", bus.mem_addr, 32'h0);
    chk("arst.pc", bus.pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h7777_7777, 1, 0, 0);
    @(negedge clk); #1;
    chk_out("idle_ack", 1, 32'h0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk_out("idle_ack2", 1, 32'h0, 0, 0, 0);

    // Redirect during the IDLE cycle replaces RESET_PC
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 1, 32'h80);
    @(negedge clk); #1;
    drive(0, 0, 0, 0, 0);
    chk_out("idle_redir", 1, 32'h80, 0, 0, 0);

`ifdef FETCH_MISALIGN_TRAP_EN
    drive(0, 0, 0, 1, 32'h0000_0102);
    @(negedge clk); #1;
    drive(1, 32'h1234_5678, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("trap.misaligned", {31'b0, bus.misaligned}, 32'h1);
      chk_out("trap", 0, 0, 0, 0, 0);
      @(negedge clk); #1;
    end
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1 chk("trap.rst_clear", {31'b0, bus.misaligned}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk_out("trap.restart", 1, 32'h0, 0, 0, 0);
`endif

    // Random traffic against the model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ph = 0; m_addr = 32'h0; m_drop = 1'b0; m_tgt = 32'h0; m_pc = 32'h0; m_ins = 32'h0;
    for (int c = 0; c < 600; c++) begin
      logic        ack, rdy, redir;
      logic [31:0] rd, rpc, rpc_al;
      #1;
      chk_out("rand", m_ph == 1, m_addr, m_ph == 2, m_ins, m_pc);
      ack   = (m_ph != 2) && ($urandom_range(0, 9) < 5);
      rdy   = $urandom_range(0, 1) == 1;
      redir = $urandom_range(0, 99) < 15;
      rd    = $urandom;
      rpc   = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      rpc_al = rpc & 32'hFFFF_FFFC;
      drive(ack, rd, rdy, redir, rpc);
      // Apply the flow rules to the model for this edge
      if (m_ph == 0) begin
        m_ph = 1;
        if (redir) m_addr = rpc_al;
      end else if (m_ph == 1) begin
        if (ack) begin
          if (redir)       begin m_addr = rpc_al; m_drop = 1'b0; end
          else if (m_drop) begin m_addr = m_tgt;  m_drop = 1'b0; end
          else             begin m_ph = 2; m_pc = m_addr; m_ins = rd; end
        end else if (redir) begin
          m_drop = 1'b1; m_tgt = rpc_al;
        end
      end else begin
        if (redir)    begin m_ph = 1; m_addr = rpc_al; end
        else if (rdy) begin m_ph = 1; m_addr = m_pc + 32'd4; end
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_req  output  1  instruction-memory read request.
REQ-005 mem_addr  output  32  word address of current request.
REQ-006 mem_ack  input  1  memory returns mem_rdata this cycle.
REQ-007 mem_rdata  input  32  instruction word, valid when mem_ack=1.
REQ-008 instr  output  32  instruction to decoder (control unit instr input).
REQ-009 instr_valid  output  1  instr/pc hold a live instruction.
REQ-010 instr_ready  input  1  decoder consumes instr this cycle.
REQ-011 pc  output  32  address of the instruction on instr.
REQ-012 redirect  input  1  branch/jump taken; discard current flow.
REQ-013 redirect_pc  input  32  target address, sampled when redirect=1.
REQ-014 misaligned  output  1  present only with FETCH_MISALIGN_TRAP_EN (REQ-031).

Function
REQ-015 FSM states IDLE, FETCH, VALID, HALT (HALT reachable only with FETCH_MISALIGN_TRAP_EN).
REQ-016 IDLE: lasts exactly one cycle after reset release, then FETCH with mem_addr=RESET_PC.
REQ-017 FETCH: mem_req=1; mem_addr stable until mem_ack; no request cancellation.
REQ-018 FETCH with mem_ack and no pending discard: register mem_rdata into instr, mem_addr into pc, go VALID next cycle.
REQ-019 VALID: instr_valid=1, mem_req=0; instr and pc held stable while instr_ready=0.
REQ-020 VALID with instr_ready=1 and redirect=0: next cycle FETCH at pc+4, instr_valid=0.
REQ-021 Minimum throughput: one instruction per 2 cycles (same-cycle ack in FETCH, accept in VALID).
REQ-022 redirect in VALID: instr_valid=0 next cycle, FETCH at redirect_pc; redirect wins over simultaneous instr_ready.
REQ-023 redirect in FETCH without mem_ack: set discard flag; mem_req/mem_addr unchanged until ack; returned word dropped; then FETCH at redirect_pc.
REQ-024 redirect in FETCH coincident with mem_ack: word dropped, next cycle FETCH at redirect_pc.
REQ-025 Second redirect while discard pending: latest redirect_pc replaces stored target.
REQ-026 redirect in IDLE: next FETCH uses redirect_pc instead of RESET_PC.
REQ-027 PC arithmetic modulo 2^32: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
REQ-028 instr_valid never asserted on the cycle after a redirect.

Reset
REQ-029 rst=1 forces immediately (asynchronously): state IDLE, mem_req=0, mem_addr=RESET_PC, instr=0, instr_valid=0, pc=RESET_PC, discard flag=0, misaligned=0.
REQ-030 Reset mid-FETCH abandons the request; any later mem_ack for it while in IDLE is ignored.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 on an accepted redirect -> HALT, misaligned=1, mem_req=0, instr_valid=0, until rst.
REQ-032 Macro undefined: no misaligned port, no HALT; redirect_pc[1:0] forced to 2'b00 when loaded.

Structure
REQ-033 fetch_state_t enum (IDLE, FETCH, VALID, HALT) and RESET_PC_DEFAULT constant SHALL live in cpu_pkg.
REQ-034 One sub-module fetch_pc: PC register, discard flag, pending-target register, next-PC mux (pc+4 / redirect_pc / RESET_PC).

Verification
REQ-035 Reset release, mem_ack on 2nd FETCH cycle with 32'h00500093, instr_ready=1 -> mem_addr 0 then 4; instr=32'h00500093, pc=0, instr_valid for one cycle.
REQ-036 VALID with instr_ready=0 for 5 cycles -> instr, pc, instr_valid constant; mem_req=0 throughout.
REQ-037 redirect to 32'h0000_0100 during FETCH of addr 8, ack 3 cycles later -> ack word never on instr; next mem_addr=32'h100.
REQ-038 redirect (32'h40) and instr_ready same cycle in VALID -> next mem_addr=32'h40, not pc+4.
REQ-039 RESET_PC=32'hFFFF_FFFC, accept first instruction -> next mem_addr=32'h0000_0000.
REQ-040 With FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h0000_0102 -> misaligned=1, mem_req=0 until rst; rst clears misaligned and restarts at RESET_PC.
